fb_wr_arbiter: RTL and testbench



---
 rtl/fb_pkg.sv | 23 ++
 rtl/fb_wr_arbiter_if.sv | 43 ++++
 rtl/fb_clear_seq.sv | 36 +++
 rtl/fb_wr_arbiter.sv | 120 ++++++++++++
 tb/tb_fb_wr_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer types and defaults for the write-port arbiter slice.
package fb_pkg;

    localparam int unsigned FB_W_DEF = 256;
    localparam int unsigned FB_H_DEF = 240;
    localparam int unsigned COORD_W  = 8;
    localparam int unsigned COL_W    = 6;

    typedef logic [COL_W-1:0]   nes_col_t;
    typedef logic [COORD_W-1:0] fb_coord_t;

    typedef struct packed {
        fb_coord_t x;
        fb_coord_t y;
        nes_col_t  col;
    } fb_wr_t;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fb_wr_arbiter_if.sv
// Requester/clear/frame-buffer write bundle between PPU+host logic and the arbiter.
interface fb_wr_arbiter_if;
    import fb_pkg::*;

    logic      ppu_req;
    fb_coord_t ppu_x;
    fb_coord_t ppu_y;
    nes_col_t  ppu_col;
    logic      ppu_gnt;

    logic      host_req;
    fb_coord_t host_x;
    fb_coord_t host_y;
    nes_col_t  host_col;
    logic      host_gnt;

    logic      clr_req;
    nes_col_t  clr_col;
    logic      clr_busy;
    logic      clr_done;

    logic      fb_we;
    fb_coord_t fb_x;
    fb_coord_t fb_y;
    nes_col_t  fb_di;

    modport master (
        output ppu_req, ppu_x, ppu_y, ppu_col,
        output host_req, host_x, host_y, host_col,
        output clr_req, clr_col,
        input  ppu_gnt, host_gnt, clr_busy, clr_done,
        input  fb_we, fb_x, fb_y, fb_di
    );

    modport slave (
        input  ppu_req, ppu_x, ppu_y, ppu_col,
        input  host_req, host_x, host_y, host_col,
        input  clr_req, clr_col,
        output ppu_gnt, host_gnt, clr_busy, clr_done,
        output fb_we, fb_x, fb_y, fb_di
    );

endinterface

// File: rtl/fb_clear_seq.sv
// Raster counter for the clear sequencer: x wraps at FB_W-1 and bumps y.
module fb_clear_seq
    import fb_pkg::*;
#(
    parameter int unsigned FB_W = FB_W_DEF,
    parameter int unsigned FB_H = FB_H_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      start,
    input  logic      adv,
    output fb_coord_t x,
    output fb_coord_t y,
    output logic      last_c
);

    localparam fb_coord_t X_LAST = fb_coord_t'(FB_W - 1);
    localparam fb_coord_t Y_LAST = fb_coord_t'(FB_H - 1);

    assign last_c = (x == X_LAST) && (y == Y_LAST);

    always_ff @(posedge clk) begin
        if (rst || start) begin
            x <= '0;
            y <= '0;
        end else if (adv) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= y + fb_coord_t'(1);
            end else begin
                x <= x + fb_coord_t'(1);
            end
        end
    end

endmodule

// File: rtl/fb_wr_arbiter.sv
// Single-port frame-buffer write arbiter (PPU over host) with a full-frame clear.
// Build option: FBARB_STARVE_GUARD_EN bounds PPU runs while the host waits.
module fb_wr_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned FB_W = FB_W_DEF,
    parameter int unsigned FB_H = FB_H_DEF
`ifdef FBARB_STARVE_GUARD_EN
    ,
    parameter int unsigned MAX_PPU_RUN = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    fb_wr_arbiter_if.slave   bus
);

    arb_state_t state;
    nes_col_t   clr_col_q;
    fb_coord_t  cx;
    fb_coord_t  cy;
    logic       last_c;
    logic       in_arb;
    logic       start_clr;
    logic       ppu_gnt_c;
    logic       host_gnt_c;
    logic       host_turn;
    fb_wr_t     wr_sel;

    assign in_arb     = (state == ARB) && !rst;
    assign start_clr  = in_arb && bus.clr_req;
    assign ppu_gnt_c  = in_arb && !bus.clr_req && bus.ppu_req && !host_turn;
    assign host_gnt_c = in_arb && !bus.clr_req && bus.host_req && !ppu_gnt_c;

    assign bus.ppu_gnt  = ppu_gnt_c;
    assign bus.host_gnt = host_gnt_c;

`ifdef FBARB_STARVE_GUARD_EN
    localparam int unsigned RUN_W = $clog2(MAX_PPU_RUN + 1);

    logic [RUN_W-1:0] run_cnt;

    assign host_turn = (run_cnt >= RUN_W'(MAX_PPU_RUN)) && bus.host_req;

    // Counts PPU wins while the host is kept waiting.
    always_ff @(posedge clk) begin
        if (rst || start_clr || !bus.host_req || host_gnt_c) begin
            run_cnt <= '0;
        end else if (ppu_gnt_c && (run_cnt < RUN_W'(MAX_PPU_RUN))) begin
            run_cnt <= run_cnt + RUN_W'(1);
        end
    end
`else
    assign host_turn = 1'b0;
`endif

    always_comb begin
        wr_sel = '{x: bus.host_x, y: bus.host_y, col: bus.host_col};
        if (ppu_gnt_c) begin
            wr_sel = '{x: bus.ppu_x, y: bus.ppu_y, col: bus.ppu_col};
        end
    end

    fb_clear_seq #(
        .FB_W (FB_W),
        .FB_H (FB_H)
    ) u_clear_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (start_clr),
        .adv    (state == CLEAR),
        .x      (cx),
        .y      (cy),
        .last_c (last_c)
    );

    // State and registered write port; a clear returns to ARB with the last pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ARB;
            clr_col_q    <= '0;
            bus.fb_we    <= 1'b0;
            bus.fb_x     <= '0;
            bus.fb_y     <= '0;
            bus.fb_di    <= '0;
            bus.clr_busy <= 1'b0;
            bus.clr_done <= 1'b0;
        end else begin
            case (state)
                ARB: begin
                    bus.clr_done <= 1'b0;
                    bus.fb_we    <= ppu_gnt_c || host_gnt_c;
                    if (ppu_gnt_c || host_gnt_c) begin
                        bus.fb_x  <= wr_sel.x;
                        bus.fb_y  <= wr_sel.y;
                        bus.fb_di <= wr_sel.col;
                    end
                    if (bus.clr_req) begin
                        state        <= CLEAR;
                        clr_col_q    <= bus.clr_col;
                        bus.clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    bus.fb_we <= 1'b1;
                    bus.fb_x  <= cx;
                    bus.fb_y  <= cy;
                    bus.fb_di <= clr_col_q;
                    if (last_c) begin
                        state        <= ARB;
                        bus.clr_busy <= 1'b0;
                        bus.clr_done <= 1'b1;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_wr_arbiter.sv
// Self-checking bench for fb_wr_arbiter against a pixel-index reference model.
module tb_fb_wr_arbiter;

    localparam int unsigned W       = 256;
    localparam int unsigned H       = 240;
    localparam int unsigned NPIX    = W * H;
    localparam int unsigned MAX_RUN = 16;
`ifdef FBARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    fb_wr_arbiter_if bus();

    fb_wr_arbiter #(
        .FB_W (W),
        .FB_H (H)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: clear progress as a linear pixel index.
    bit         m_clearing;
    int         m_idx;
    int         m_run;
    logic [5:0] m_col;
    logic       e_we, e_busy, e_done;
    logic [7:0] e_x, e_y;
    logic [5:0] e_di;
    bit         e_gp, e_gh;
    int         n_pg, n_hg, n_done, n_clrwr;
    int         pg0, hg0, wr0, d0, cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit host_first;
        #1;
        e_gp = 1'b0;
        e_gh = 1'b0;
        if (!rst && !m_clearing && !bus.clr_req) begin
            host_first = GUARD && (m_run >= int'(MAX_RUN)) && bus.host_req;
            e_gp = bus.ppu_req && !host_first;
            e_gh = bus.host_req && !e_gp;
        end
        chk("ppu_gnt", 32'(bus.ppu_gnt), 32'(e_gp));
        chk("host_gnt", 32'(bus.host_gnt), 32'(e_gh));
        n_pg += int'(bus.ppu_gnt);
        n_hg += int'(bus.host_gnt);

        if (rst) begin
            m_clearing = 1'b0; m_idx = 0; m_run = 0; m_col = '0;
            e_we = 1'b0; e_x = '0; e_y = '0; e_di = '0; e_busy = 1'b0; e_done = 1'b0;
        end else if (m_clearing) begin
            e_we   = 1'b1;
            e_x    = 8'(m_idx % int'(W));
            e_y    = 8'(m_idx / int'(W));
            e_di   = m_col;
            e_done = (m_idx == int'(NPIX) - 1);
            e_busy = !e_done;
            m_clearing = !e_done;
            m_idx++;
        end else if (bus.clr_req) begin
            m_clearing = 1'b1; m_idx = 0; m_run = 0; m_col = bus.clr_col;
            e_we = 1'b0; e_busy = 1'b1; e_done = 1'b0;
        end else begin
            e_we = e_gp || e_gh;
            if (e_gp) begin
                e_x = bus.ppu_x; e_y = bus.ppu_y; e_di = bus.ppu_col;
            end else if (e_gh) begin
                e_x = bus.host_x; e_y = bus.host_y; e_di = bus.host_col;
            end
            e_busy = 1'b0;
            e_done = 1'b0;
            if (!bus.host_req) m_run = 0;
            else if (e_gp)     m_run++;
            else               m_run = 0;
        end

        @(posedge clk);
        #1;
        chk("fb_we", 32'(bus.fb_we), 32'(e_we));
        chk("fb_x", 32'(bus.fb_x), 32'(e_x));
        chk("fb_y", 32'(bus.fb_y), 32'(e_y));
        chk("fb_di", 32'(bus.fb_di), 32'(e_di));
        chk("clr_busy", 32'(bus.clr_busy), 32'(e_busy));
        chk("clr_done", 32'(bus.clr_done), 32'(e_done));
        n_done += int'(bus.clr_done);
        if (bus.fb_we && (bus.clr_busy || bus.clr_done)) n_clrwr++;
    endtask

    initial begin
        n_pg = 0; n_hg = 0; n_done = 0; n_clrwr = 0;
        rst = 1'b1;
        bus.ppu_req = 1'b1; bus.ppu_x = 8'h33; bus.ppu_y = 8'h44; bus.ppu_col = 6'h15;
        bus.host_req = 1'b0; bus.host_x = '0; bus.host_y = '0; bus.host_col = '0;
        bus.clr_req = 1'b0; bus.clr_col = '0;
        @(posedge clk);
        #1;

        // Reset with PPU request held
        repeat (3) step();
        #1;
        chk("rst_ppu_gnt", 32'(bus.ppu_gnt), 32'd0);
        chk("rst_fb_we", 32'(bus.fb_we), 32'd0);
        rst = 1'b0;
        step();
        chk("first_wr_we", 32'(bus.fb_we), 32'd1);
        chk("first_wr_x", 32'(bus.fb_x), 32'h33);
        chk("first_wr_y", 32'(bus.fb_y), 32'h44);
        chk("first_wr_di", 32'(bus.fb_di), 32'h15);

        // Host only
        bus.ppu_req = 1'b0;
        bus.host_req = 1'b1; bus.host_x = 8'd10; bus.host_y = 8'd20; bus.host_col = 6'h27;
        #1;
        chk("host_gnt_same_cycle", 32'(bus.host_gnt), 32'd1);
        step();
        chk("host_wr_we", 32'(bus.fb_we), 32'd1);
        chk("host_wr_x", 32'(bus.fb_x), 32'd10);
        chk("host_wr_y", 32'(bus.fb_y), 32'd20);
        chk("host_wr_di", 32'(bus.fb_di), 32'h27);
        bus.host_req = 1'b0;
        step();
        chk("host_wr_end", 32'(bus.fb_we), 32'd0);

        // Both requesters held for 40 cycles
        pg0 = n_pg; hg0 = n_hg;
        bus.ppu_req = 1'b1; bus.host_req = 1'b1;
        repeat (40) step();
        chk("both_ppu_grants", 32'(n_pg - pg0), GUARD ? 32'd38 : 32'd40);
        chk("both_host_grants", 32'(n_hg - hg0), GUARD ? 32'd2 : 32'd0);
        bus.ppu_req = 1'b0; bus.host_req = 1'b0;
        step();

        // Randomised traffic, requests held until granted
        repeat (400) begin
            if (!bus.ppu_req || e_gp) begin
                bus.ppu_req = 1'($urandom_range(0, 1));
                bus.ppu_x = 8'($urandom); bus.ppu_y = 8'($urandom); bus.ppu_col = 6'($urandom);
            end
            if (!bus.host_req || e_gh) begin
                bus.host_req = 1'($urandom_range(0, 1));
                bus.host_x = 8'($urandom); bus.host_y = 8'($urandom); bus.host_col = 6'($urandom);
            end
            step();
        end

        // Full clear with a concurrent PPU request and an ignored mid-clear clr_req
        bus.host_req = 1'b0;
        bus.ppu_req = 1'b1; bus.ppu_x = 8'd5; bus.ppu_y = 8'd6; bus.ppu_col = 6'h07;
        bus.clr_req = 1'b1; bus.clr_col = 6'h0F;
        #1;
        chk("clr_blocks_ppu", 32'(bus.ppu_gnt), 32'd0);
        step();
        bus.clr_req = 1'b0;
        wr0 = n_clrwr; d0 = n_done; cyc = 0;
        while (bus.clr_busy && cyc < int'(NPIX) + 16) begin
            bus.clr_req = (cyc == 500);
            bus.clr_col = (cyc == 500) ? 6'h15 : 6'h0F;
            step();
            cyc++;
        end
        bus.clr_req = 1'b0;
        chk("clr_done_pulse", 32'(bus.clr_done), 32'd1);
        chk("clr_last_x", 32'(bus.fb_x), 32'd255);
        chk("clr_last_y", 32'(bus.fb_y), 32'd239);
        chk("clr_write_count", 32'(n_clrwr - wr0), NPIX);
        chk("clr_done_count", 32'(n_done - d0), 32'd1);
        #1;
        chk("ppu_gnt_after_clear", 32'(bus.ppu_gnt), 32'd1);
        step();
        chk("ppu_wr_after_clear", 32'(bus.fb_x), 32'd5);
        bus.ppu_req = 1'b0;
        step();

        // Reset at clear pixel 1000, then restart
        bus.clr_req = 1'b1; bus.clr_col = 6'h2A;
        step();
        bus.clr_req = 1'b0;
        wr0 = n_clrwr; d0 = n_done; cyc = 0;
        while ((n_clrwr - wr0) < 1000 && cyc < 2000) begin
            step();
            cyc++;
        end
        chk("pix_1000_count", 32'(n_clrwr - wr0), 32'd1000);
        chk("pix_1000_x", 32'(bus.fb_x), 32'd231);
        chk("pix_1000_y", 32'(bus.fb_y), 32'd3);
        rst = 1'b1;
        step();
        chk("abort_busy", 32'(bus.clr_busy), 32'd0);
        chk("abort_we", 32'(bus.fb_we), 32'd0);
        rst = 1'b0;
        step();
        chk("abort_no_done", 32'(n_done - d0), 32'd0);
        bus.clr_req = 1'b1; bus.clr_col = 6'h2A;
        step();
        bus.clr_req = 1'b0;
        step();
        chk("restart_x0", 32'(bus.fb_x), 32'd0);
        chk("restart_y0", 32'(bus.fb_y), 32'd0);
        chk("restart_di", 32'(bus.fb_di), 32'h2A);
        step();
        chk("restart_x1", 32'(bus.fb_x), 32'd1);
        repeat (300) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
